// File: rtl/sr_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_bank_pkg
//  Description : Shared mode encodings and next-state helper for the SR bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package sr_bank_pkg;

  // Response of a channel to a simultaneous set and reset request
  localparam int SRB_HOLD    = 0;
  localparam int SRB_SET_DOM = 1;
  localparam int SRB_RST_DOM = 2;
  localparam int SRB_TOGGLE  = 3;

  // Next state of one SR bit; unknown modes fall back to hold
  function automatic logic srb_next(input logic q, input logic s,
                                    input logic r, input int mode);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        case (mode)
          SRB_SET_DOM: nq = 1'b1;
          SRB_RST_DOM: nq = 1'b0;
          SRB_TOGGLE:  nq = ~q;
          default:     nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sr_ff_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr_ff_bank_if
//  Description : Request/status bundle between a controller and the SR bank.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sr_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic             clr_conflict;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_n;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, S, R, clr_conflict,
    input  Q, Q_n, rise, fall, conflict, conflict_cnt
  );

  modport slave (
    input  en, S, R, clr_conflict,
    output Q, Q_n, rise, fall, conflict, conflict_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sr_cell.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cell
//  Description : One clocked SR storage bit with edge pulses and a sticky
//                conflict flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int   MODE    = SRB_HOLD,
  parameter logic RST_VAL = 1'b0
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  en,
  input  wire  s,
  input  wire  r,
  input  wire  clr,
  output logic q,
  output logic rise,
  output logic fall,
  output logic conflict,
  output logic hit
);

  logic w_next;

  // Conflict this cycle; only counted while the bank is enabled
  assign hit    = en & s & r;
  assign w_next = en ? srb_next(q, s, r, MODE) : q;

  // State, edge pulses and sticky flag; a same-cycle conflict beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= RST_VAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      q        <= w_next;
      rise     <= w_next & ~q;
      fall     <= ~w_next & q;
      conflict <= hit | (conflict & ~clr);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sr_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sr_ff_bank
//  Description : WIDTH-channel clocked SR register bank with edge pulses,
//                sticky conflict flags and a saturating conflict counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = SRB_HOLD,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input wire         clk,
  input wire         rst_n,
  sr_ff_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_conf;
  logic [WIDTH-1:0] w_hit;
  logic             w_any;
  logic [CNT_W-1:0] r_cnt;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_cell #(
        .MODE    (MODE),
        .RST_VAL (RST_VAL[i])
      ) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .s        (bus.S[i]),
        .r        (bus.R[i]),
        .clr      (bus.clr_conflict),
        .q        (w_q[i]),
        .rise     (w_rise[i]),
        .fall     (w_fall[i]),
        .conflict (w_conf[i]),
        .hit      (w_hit[i])
      );
    end
  endgenerate

  // One event per cycle regardless of how many channels conflict
  assign w_any = |w_hit;

  // Saturating event counter; a conflict in the clearing cycle restarts at 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.clr_conflict) begin
      r_cnt <= w_any ? c_cnt_one : '0;
    end else if (w_any && (r_cnt != c_cnt_max)) begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  assign bus.Q            = w_q;
  assign bus.Q_n          = ~w_q;
  assign bus.rise         = w_rise;
  assign bus.fall         = w_fall;
  assign bus.conflict     = w_conf;
  assign bus.conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised, clocked successor to the team's single-bit level-sensitive SR latch.
- Holds WIDTH independent SR storage bits, all updated on one clock edge.
- S=R=1 behaviour is selectable by parameter: hold, set-dominant, reset-dominant or toggle (JK).
- Adds registered edge pulses, per-channel sticky conflict flags and a saturating conflict-event counter; used for status/alarm capture in control logic.

Parameters:
- WIDTH, 8, number of SR channels (1..32).
- MODE, 0, response to S=R=1: 0 hold, 1 set-dominant, 2 reset-dominant, 3 toggle.
- RST_VAL, {WIDTH{1'b0}}, per-channel value loaded into Q on reset.
- CNT_W, 8, width of the conflict-event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global update enable; 0 freezes Q.
- S  in  WIDTH  per-channel set request.
- R  in  WIDTH  per-channel reset request.
- clr_conflict  in  1  synchronous clear of conflict flags and counter.
- Q  out  WIDTH  stored state.
- Q_n  out  WIDTH  bitwise inverse of Q, combinational from Q.
- rise  out  WIDTH  one-cycle pulse in the same cycle Q[i] first reads 1 after a 0.
- fall  out  WIDTH  one-cycle pulse in the same cycle Q[i] first reads 0 after a 1.
- conflict  out  WIDTH  sticky flag: channel saw S=R=1 while en=1.
- conflict_cnt  out  CNT_W  count of cycles with any conflict; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - Q=RST_VAL, rise=0, fall=0, conflict=0, conflict_cnt=0.
  - Release is synchronous to the next clk edge.
  - Reset asserted mid-operation discards any pending update.
- Per channel i, at each clk rising edge with en=1, S/R are sampled and Q[i] updates with 1-cycle latency:
  - S=1, R=0: Q[i] becomes 1.
  - S=0, R=1: Q[i] becomes 0.
  - S=0, R=0: Q[i] holds.
  - S=1, R=1: result depends on MODE. 0 holds, 1 sets, 2 clears, 3 inverts.
- en=0:
  - Q holds; rise and fall are 0.
  - No conflict is recorded and the counter does not change.
- Edge pulses:
  - rise[i] and fall[i] are registered alongside Q from next-state versus current state.
  - Each lasts exactly one cycle unless Q[i] toggles again in the next cycle.
  - In MODE 3 with continuous S=R=1, rise and fall alternate every cycle.
- Conflict flags:
  - conflict[i] is set on any en=1 cycle with S[i]&R[i], in every MODE, and stays set until cleared.
  - conflict_cnt increments by 1 per cycle in which any channel conflicts (not per channel).
  - The counter saturates at 2^CNT_W-1 and never wraps.
- clr_conflict=1:
  - Next edge clears conflict and conflict_cnt.
  - If a conflict occurs in the same cycle, the new event wins: conflict = that cycle's conflict vector, conflict_cnt=1.
  - clr_conflict does not affect Q, rise or fall.
- Any undefined MODE value is treated as MODE 0.
- No combinational path from S/R to Q; only Q_n is combinational (from Q).

Decomposition:
- Package sr_bank_pkg holds:
  - mode localparams: SRB_HOLD=0, SRB_SET_DOM=1, SRB_RST_DOM=2, SRB_TOGGLE=3;
  - a helper function returning next-state from (q, s, r, mode).
- One sub-module, sr_cell: a single-channel flop with next-state, rise/fall and conflict-bit logic. It is instantiated WIDTH times via generate.
- The conflict counter and any-conflict reduction live in sr_ff_bank top.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with RST_VAL=8'hA5 -> Q=8'hA5 immediately, Q_n=8'h5A, all flags and conflict_cnt=0.
- Basic set/reset, WIDTH=8, MODE=0, en=1: S=8'h0F, R=0 for one cycle -> Q=8'h0F next cycle, rise=8'h0F for one cycle; then R=8'h03 -> Q=8'h0C, fall=8'h03.
- Conflict per MODE: Q[0]=0, S[0]=R[0]=1 for 3 cycles:
  - MODE 0 -> Q[0] stays 0;
  - MODE 1 -> Q[0]=1;
  - MODE 2 -> Q[0]=0;
  - MODE 3 -> Q[0] goes 1,0,1 with alternating rise/fall;
  - every MODE -> conflict[0]=1, conflict_cnt=3.
- Enable gating: en=0 with S=8'hFF, R=8'hFF for 5 cycles -> Q unchanged, rise=fall=0, conflict_cnt unchanged.
- Saturation and clear, CNT_W=2: 6 conflict cycles -> conflict_cnt=3 (held); clr_conflict=1 with conflict on ch2 the same cycle -> conflict=8'h04, conflict_cnt=1.
- Async reset during MODE 3 toggling -> Q returns to RST_VAL without waiting for clk; the first edge after release applies the sampled S/R normally.
